// File: rtl/alu4_pkg.sv
// alu4_pkg: shared definitions for the alu4 issue/writeback slice.
//   DATA_W      - datapath width of the 4-bit ALU and register file
//   OP_ADD..OP_EQ - ALU opcode encodings (000..111)
//   flags_t     - packed {zero, carry, ovf}; zero is bit 2, ovf is bit 0
package alu4_pkg;

  localparam int DATA_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu4_regfile.sv
// alu4_regfile: 2**REG_AW x DATA_W register file, R0 hardwired to zero.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset (clears all entries)
//   rs1_addr / rs1_data - combinational read port A
//   rs2_addr / rs2_data - combinational read port B
//   wr_en, wr_addr, wr_data - synchronous write port; writes to R0 are dropped
module alu4_regfile
  import alu4_pkg::*;
#(
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/alu4_issue.sv
// alu4_issue: issue/writeback stage in front of an external combinational 4-bit ALU.
// Instructions are accepted on in_valid/in_ready, operands are read from the
// register file (with forwarding from the retiring result) into a single execute
// register that drives the ALU. The ALU result retires on res_valid/res_ready,
// is written back to the register file and updates the flags register.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   in_valid/in_ready               - instruction handshake
//   in_op, in_rd, in_rs1, in_rs2    - opcode and register addresses
//   in_use_imm, in_imm              - immediate select and value for operand B
//   alu_a, alu_b, alu_op            - registered ALU operands/opcode
//   alu_out, alu_zero/carry/ovf     - ALU result and flags (combinational)
//   res_valid/res_ready             - result stream handshake
//   res_data, res_rd                - retiring result and its destination
//   flags                           - {zero,carry,ovf} of last retired instruction
// Optional (macro ALU4_STICKY_OVF_EN):
//   ovf_clr    - clears the sticky overflow bit (a simultaneous set wins)
//   sticky_ovf - set by any retire with alu_ovf=1
module alu4_issue
  import alu4_pkg::*;
#(
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_use_imm,
  input  logic [3:0]        in_imm,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [2:0]        alu_op,
  input  logic [3:0]        alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [3:0]        res_data,
  output logic [REG_AW-1:0] res_rd,
  output logic [2:0]        flags
`ifdef ALU4_STICKY_OVF_EN
  ,
  input  logic              ovf_clr,
  output logic              sticky_ovf
`endif
);

  logic                     vld_p1;
  logic [2:0]               op_p1;
  logic [REG_AW-1:0]        rd_p1;
  logic [DATA_W-1:0]        a_p1;
  logic [DATA_W-1:0]        b_p1;
  flags_t                   flags_q;

  logic                     issue;
  logic                     retire;
  logic                     fwd_en;
  logic [DATA_W-1:0]        rs1_data;
  logic [DATA_W-1:0]        rs2_data;
  logic [DATA_W-1:0]        a_p0;
  logic [DATA_W-1:0]        b_p0;

  // Forwarding mux: when the instruction in E retires on the same edge and
  // targets the register being read, the register file still holds the old
  // value, so the ALU result is taken directly instead.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic              hit,
    input logic [DATA_W-1:0] fwd_val,
    input logic [DATA_W-1:0] rf_val
  );
    return hit ? fwd_val : rf_val;
  endfunction

  assign in_ready = !vld_p1 || res_ready;
  assign issue    = in_valid && in_ready;
  assign retire   = vld_p1 && res_ready;
  // R0 is never written, so a retire to R0 must not forward.
  assign fwd_en   = retire && (rd_p1 != '0);

  alu4_regfile #(
    .REG_AW(REG_AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs1_addr(in_rs1),
    .rs1_data(rs1_data),
    .rs2_addr(in_rs2),
    .rs2_data(rs2_data),
    .wr_en   (retire),
    .wr_addr (rd_p1),
    .wr_data (alu_out)
  );

  // Stage 0: operand selection (register file, forwarding, immediate)
  assign a_p0 = fwd_sel(fwd_en && (in_rs1 == rd_p1), alu_out, rs1_data);
  assign b_p0 = in_use_imm ? in_imm
                           : fwd_sel(fwd_en && (in_rs2 == rd_p1), alu_out, rs2_data);

  // Stage 1: execute register feeding the ALU; holds while the result is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      op_p1   <= '0;
      rd_p1   <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
      flags_q <= '0;
    end else begin
      if (issue) begin
        vld_p1 <= 1'b1;
        op_p1  <= in_op;
        rd_p1  <= in_rd;
        a_p1   <= a_p0;
        b_p1   <= b_p0;
      end else if (retire) begin
        vld_p1 <= 1'b0;
      end
      if (retire) begin
        flags_q <= '{zero: alu_zero, carry: alu_carry, ovf: alu_ovf};
      end
    end
  end

`ifdef ALU4_STICKY_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (retire && alu_ovf) begin
      sticky_ovf <= 1'b1;
    end else if (ovf_clr) begin
      sticky_ovf <= 1'b0;
    end
  end
`endif

  assign alu_a     = a_p1;
  assign alu_b     = b_p1;
  assign alu_op    = op_p1;
  assign res_valid = vld_p1;
  assign res_data  = alu_out;
  assign res_rd    = rd_p1;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu4_issue.sv
// tb_alu4_issue: self-checking bench for alu4_issue.
// Provides a stand-in combinational ALU, a program-order reference model of the
// register file / flags / result stream, directed scenarios with literal
// expectations, and a randomized phase. Honours ALU4_STICKY_OVF_EN.
module tb_alu4_issue;
  import alu4_pkg::*;

  localparam int REG_AW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [REG_AW-1:0] in_rd;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic              in_use_imm;
  logic [3:0]        in_imm;
  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic [2:0]        alu_op;
  logic [3:0]        alu_out;
  logic              alu_zero;
  logic              alu_carry;
  logic              alu_ovf;
  logic              res_valid;
  logic              res_ready;
  logic [3:0]        res_data;
  logic [REG_AW-1:0] res_rd;
  logic [2:0]        flags;
`ifdef ALU4_STICKY_OVF_EN
  logic              ovf_clr;
  logic              sticky_ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu4_issue #(.REG_AW(REG_AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_use_imm(in_use_imm),
    .in_imm    (in_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .alu_ovf   (alu_ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .flags     (flags)
`ifdef ALU4_STICKY_OVF_EN
    ,
    .ovf_clr   (ovf_clr),
    .sticky_ovf(sticky_ovf)
`endif
  );

  // ALU behaviour: returns {result[3:0], zero, carry, ovf}. Sub reports borrow as carry.
  function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    int sa, sb, s;
    logic [3:0] r;
    logic c, v;
    sa = (a >= 8) ? int'(a) - 16 : int'(a);
    sb = (b >= 8) ? int'(b) - 16 : int'(b);
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b); r = 4'(s); c = (s > 15);
                  v = (sa + sb > 7) || (sa + sb < -8); end
      3'd1: begin s = int'(a) - int'(b); r = 4'(s); c = (a < b);
                  v = (sa - sb > 7) || (sa - sb < -8); end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = (sa < sb) ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {r, (r == 4'd0), c, v};
  endfunction

  always_comb {alu_out, alu_zero, alu_carry, alu_ovf} = alu_f(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: instructions executed in program order at acceptance.
  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic [2:0] fl;
  } exp_t;

  logic [3:0] mregs [4];
  exp_t       q[$];
  logic [2:0] mflags;
  logic       msticky;

  always @(negedge clk) begin
    exp_t e;
    logic [6:0] r;
    logic rdy_m;
    logic ret_ovf;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mregs[i] = '0;
      q.delete();
      mflags  = '0;
      msticky = 1'b0;
    end else begin
      chk("in_ready", int'(in_ready), int'(q.size() == 0 || res_ready));
      chk("res_valid", int'(res_valid), int'(q.size() != 0));
      chk("flags", int'(flags), int'(mflags));
`ifdef ALU4_STICKY_OVF_EN
      chk("sticky_ovf", int'(sticky_ovf), int'(msticky));
`endif
      if (q.size() != 0) begin
        chk("alu_a", int'(alu_a), int'(q[0].a));
        chk("alu_b", int'(alu_b), int'(q[0].b));
        chk("alu_op", int'(alu_op), int'(q[0].op));
        chk("res_data", int'(res_data), int'(q[0].res));
        chk("res_rd", int'(res_rd), int'(q[0].rd));
      end
      rdy_m   = (q.size() == 0) || res_ready;
      ret_ovf = 1'b0;
      if (q.size() != 0 && res_ready) begin
        mflags  = q[0].fl;
        ret_ovf = q[0].fl[0];
        void'(q.pop_front());
      end
`ifdef ALU4_STICKY_OVF_EN
      if (ret_ovf) msticky = 1'b1;
      else if (ovf_clr) msticky = 1'b0;
`endif
      if (in_valid && rdy_m) begin
        e.op = in_op;
        e.rd = in_rd;
        e.a  = mregs[in_rs1];
        e.b  = in_use_imm ? in_imm : mregs[in_rs2];
        r    = alu_f(e.op, e.a, e.b);
        e.res = r[6:3];
        e.fl  = r[2:0];
        q.push_back(e);
        if (in_rd != 0) mregs[in_rd] = e.res;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic ui, input logic [3:0] imm);
    int waited;
    waited     = 0;
    in_valid   = 1'b1;
    in_op      = op;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_use_imm = ui;
    in_imm     = imm;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = '0;
    in_rd      = '0;
    in_rs1     = '0;
    in_rs2     = '0;
    in_use_imm = 1'b0;
    in_imm     = '0;
    res_ready  = 1'b1;
`ifdef ALU4_STICKY_OVF_EN
    ovf_clr    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_b", int'(alu_b), 0);
    chk("rst_alu_op", int'(alu_op), 0);
    chk("rst_flags", int'(flags), 0);
    rst_n = 1'b1;
    step();

    // OR r1, r0, #5
    send(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5);
    chk("or5_valid", int'(res_valid), 1);
    chk("or5_data", int'(res_data), 5);
    chk("or5_rd", int'(res_rd), 1);

    // add r2, r1, #3 then add r3, r2, #1 back to back
    send(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 4'd3);
    chk("add8_a", int'(alu_a), 5);
    chk("add8_data", int'(res_data), 8);
    send(OP_ADD, 2'd3, 2'd2, 2'd0, 1'b1, 4'd1);
    chk("add9_valid", int'(res_valid), 1);
    chk("add9_data", int'(res_data), 9);
    chk("flags_5p3", int'(flags), 3'b001);

    // Stall three cycles
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_alu_a", int'(alu_a), 8);
      chk("stall_alu_b", int'(alu_b), 1);
      chk("stall_alu_op", int'(alu_op), int'(OP_ADD));
      chk("stall_flags", int'(flags), 3'b001);
    end
    res_ready = 1'b1;
    step();
    chk("unstall_valid", int'(res_valid), 0);
    chk("flags_8p1", int'(flags), 3'b000);

    // sub r1, r1, r1 (r1 = 5)
    send(OP_SUB, 2'd1, 2'd1, 2'd1, 1'b0, 4'd0);
    chk("sub_a", int'(alu_a), 5);
    chk("sub_data", int'(res_data), 0);
    step();
    chk("flags_sub", int'(flags), 3'b100);

    // OR r0, r0, #7 then read r0
    send(OP_OR, 2'd0, 2'd0, 2'd0, 1'b1, 4'd7);
    chk("r0w_data", int'(res_data), 7);
    chk("r0w_rd", int'(res_rd), 0);
    step();
    chk("flags_r0w", int'(flags), 3'b000);
    send(OP_OR, 2'd3, 2'd0, 2'd0, 1'b0, 4'd0);
    chk("r0_reads_0", int'(res_data), 0);
    step();

`ifdef ALU4_STICKY_OVF_EN
    ovf_clr = 1'b1;
    step();
    chk("sticky_clr", int'(sticky_ovf), 0);
    ovf_clr = 1'b0;
    send(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'd7);
    send(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 4'd1);
    step();
    chk("sticky_set", int'(sticky_ovf), 1);
    send(OP_OR, 2'd2, 2'd0, 2'd0, 1'b1, 4'd1);
    step();
    chk("sticky_hold", int'(sticky_ovf), 1);
    ovf_clr = 1'b1;
    send(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 4'd7);
    send(OP_ADD, 2'd2, 2'd2, 2'd0, 1'b1, 4'd1);
    step();
    chk("sticky_set_wins", int'(sticky_ovf), 1);
    step();
    chk("sticky_cleared", int'(sticky_ovf), 0);
    ovf_clr = 1'b0;
`endif

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_op      = 3'($urandom_range(0, 7));
      in_rd      = 2'($urandom_range(0, 3));
      in_rs1     = 2'($urandom_range(0, 3));
      in_rs2     = 2'($urandom_range(0, 3));
      in_use_imm = 1'($urandom_range(0, 1));
      in_imm     = 4'($urandom_range(0, 15));
      res_ready  = ($urandom_range(0, 3) != 0);
`ifdef ALU4_STICKY_OVF_EN
      ovf_clr    = ($urandom_range(0, 7) == 0);
`endif
      step();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
`ifdef ALU4_STICKY_OVF_EN
    ovf_clr   = 1'b0;
`endif
    step();

    // Reset asserted while stalled
    res_ready = 1'b0;
    send(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3);
    step();
    chk("pre_rst_valid", int'(res_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_valid", int'(res_valid), 0);
    chk("mid_rst_alu_a", int'(alu_a), 0);
    chk("mid_rst_alu_b", int'(alu_b), 0);
    chk("mid_rst_alu_op", int'(alu_op), 0);
    chk("mid_rst_flags", int'(flags), 0);
`ifdef ALU4_STICKY_OVF_EN
    chk("mid_rst_sticky", int'(sticky_ovf), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    res_ready = 1'b1;
    step();
    send(OP_OR, 2'd2, 2'd1, 2'd0, 1'b1, 4'd0);
    chk("rf_cleared_r1", int'(res_data), 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu4_issue.md
Name: alu4_issue

Overview:
- Issue/writeback stage placed directly upstream of the team's 4-bit combinational ALU.
- Accepts instructions over a valid/ready handshake and reads operands from a small register file. Drives A/B/op to the ALU from a registered execute stage.
- Writes the ALU result and flags back and presents each retired result on an output stream with backpressure.
- Forwards the retiring result to the next issuing instruction.

Parameters:
- REG_AW, 2, register address width; the register file holds 2**REG_AW 4-bit registers; legal values 1..3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_op  in  3  ALU opcode: 000 add, 001 sub, 010 not A, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
- in_rd  in  REG_AW  destination register.
- in_rs1  in  REG_AW  source A register.
- in_rs2  in  REG_AW  source B register.
- in_use_imm  in  1  1 selects in_imm for B instead of rs2.
- in_imm  in  4  immediate B operand.
- alu_a  out  4  operand A to the ALU.
- alu_b  out  4  operand B to the ALU.
- alu_op  out  3  opcode to the ALU.
- alu_out  in  4  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry flag.
- alu_ovf  in  1  ALU overflow flag.
- res_valid  out  1  retiring result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  4  equals alu_out.
- res_rd  out  REG_AW  destination of the retiring result.
- flags  out  3  registered {zero,carry,overflow} of the last retired instruction.

Behaviour:
- Reset (async, rst_n=0): all registers = 0, E-stage valid = 0, flags = 0. Outputs: in_ready=1, res_valid=0, alu_a/alu_b/alu_op=0.
- R0 is hardwired to 0. Writes to R0 are discarded, but the instruction still retires and flags still update.
- E-stage register holds {valid_e, op, rd, a, b}. alu_a/alu_b/alu_op are driven only from this register.
- in_ready = !valid_e || res_ready (combinational).
- Issue: the instruction is accepted when in_valid && in_ready.
  - On the accepting edge the E-stage loads op, rd, a = rs1 value, and b = (use_imm ? imm : rs2 value).
  - valid_e is set to 1 on that edge.
- Latency: an instruction accepted at edge N appears on res_valid during cycle N..N+1 (one cycle after acceptance).
- Retire: occurs when valid_e && res_ready. On that edge:
  - regfile[rd] <= alu_out (unless rd=0).
  - flags <= {alu_zero, alu_carry, alu_ovf}.
  - valid_e clears unless a new instruction issues on the same edge.
- Stall: while res_valid && !res_ready, the E-stage holds and alu_* stay stable. No register write occurs and in_ready=0.
- Forwarding: on the same edge as a retire with rd!=0, an issuing instruction with rs1==rd takes alu_out for a. Likewise rs2==rd (with use_imm=0) takes alu_out for b. Back-to-back dependent instructions therefore issue without bubbles.
- res_data, res_rd and res_valid are combinational from the E-stage and ALU. res_valid = valid_e.
- Simultaneous retire and issue is allowed and gives full throughput of 1 instruction/cycle.
- Reset mid-operation drops any in-flight instruction. The register file clears.

Optional Feature:
- ALU4_STICKY_OVF_EN: adds ports ovf_clr (in, 1) and sticky_ovf (out, 1).
  - sticky_ovf sets on any retire with alu_ovf=1.
  - It clears on ovf_clr=1; if set and clear coincide, set wins. Reset value is 0.
- Without the macro these ports are absent and no sticky logic exists.

Decomposition:
- Shared package alu4_pkg:
  - opcode constants OP_ADD..OP_EQ (000..111).
  - DATA_W=4.
  - a flags struct {zero, carry, ovf} with bit order zero=2, carry=1, ovf=0.
- One sub-module alu4_regfile: 2**REG_AW x 4 with two combinational read ports, one synchronous write port, R0 reads 0, async active-low reset clears all entries.

Test Plan:
- Reset then issue OR r1,r0,imm=5 with res_ready=1 -> next cycle res_valid=1, res_data=5, res_rd=1; a subsequent read of r1 returns 5.
- Back-to-back add r2,r1,imm=3 then add r3,r2,imm=1 (r1=5) -> res_data=8 then 9, no bubble, second result forwarded. flags after the 5+3 retire: overflow=1, zero=0.
- Hold res_ready=0 for 3 cycles with valid_e=1 -> in_ready=0, alu_a/alu_b/alu_op stable, r-file unchanged. Raising res_ready -> retire on the next edge.
- sub r1,r1,r1 with r1=5 -> res_data=0, flags zero=1, carry=0, overflow=0.
- Write to r0 (OR r0,r0,imm=7) -> res_data=7, flags updated, r0 still reads 0.
- With ALU4_STICKY_OVF_EN: 7+1 sets sticky_ovf=1; it stays set through non-overflowing ops. ovf_clr=1 on the same edge as a retire with alu_ovf=1 -> sticky_ovf remains 1. Assert rst_n=0 mid-stall -> all outputs go to reset values immediately.
